// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline package: payload structs for the IF/ID, ID/EX and EX/WB
// boundaries, their packed widths, and the pointer-wrap helper used by
// pipe_elastic_stage.
package riscv_pipe_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [31:0] instr;
      logic        no_op;
   } if_id_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [31:0] rdata1;
      logic [31:0] rdata2;
      logic [31:0] imm;
      logic [3:0]  alu_op;
      logic        alu_src;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        jump;
      logic [2:0]  ls_type;
      logic        write_en;
      logic [4:0]  rd;
      logic        no_op;
   } id_ex_t;

   typedef struct packed {
      logic [31:0] pc_plus4;
      logic [31:0] ex_data;
      logic [31:0] mem_data;
      logic [2:0]  ls_type;
      logic        write_en;
      logic        comp_flag;
      logic [4:0]  rd;
      logic        no_op;
   } ex_wb_t;

   localparam int IF_ID_W = $bits(if_id_t);
   localparam int ID_EX_W = $bits(id_ex_t);
   localparam int EX_WB_W = $bits(ex_wb_t);

   // Circular-buffer pointer increment: wraps depth-1 -> 0 by compare so
   // non-power-of-two depths work.
   function automatic logic [31:0] ptr_inc(input logic [31:0] ptr,
                                           input logic [31:0] depth);
      logic [31:0] nxt;
      if (ptr == (depth - 32'd1)) begin
         nxt = 32'd0;
      end else begin
         nxt = ptr + 32'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline register: DEPTH-entry circular buffer with valid/ready on
// both sides, per-stage stall and flush. Priority: rst > flush > stall.
// Optional feature macro PIPE_BYPASS_EN: an empty stage forwards the input
// combinationally (zero latency) when downstream is ready.
module pipe_elastic_stage
   import riscv_pipe_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_i,
   input  logic                  stall_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic [CW-1:0]         count_o
);

   localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]         wr_ptr_r;
   logic [PW-1:0]         rd_ptr_r;
   logic [CW-1:0]         count_r;

   logic active_s;
   logic empty_s;
   logic full_s;
   logic bypass_s;
   logic push_s;
   logic pop_s;
   logic [DATA_WIDTH-1:0] head_s;

   // Stage may only transfer when not in reset, not flushing and not stalled.
   assign active_s = !rst && !flush_i && !stall_i;
   assign empty_s  = (count_r == {CW{1'b0}});
   assign full_s   = (count_r >= DEPTH_C);
   assign head_s   = empty_s ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_r];

`ifdef PIPE_BYPASS_EN
   // Empty stage with valid input presents that input downstream directly.
   assign bypass_s = active_s && empty_s && in_valid_i;
`else
   assign bypass_s = 1'b0;
`endif

   // in_ready ignores out_ready, so a full stage refuses input even while popping.
   assign in_ready_o  = active_s && !full_s;
   assign out_valid_o = active_s && (!empty_s || bypass_s);
   assign out_data_o  = bypass_s ? in_data_i : head_s;
   assign count_o     = count_r;

   // A bypassed payload consumed the same cycle never touches storage.
   assign push_s = in_valid_i && in_ready_o && !(bypass_s && out_ready_i);
   assign pop_s  = out_valid_o && out_ready_i && !empty_s;

   // Pointer and occupancy update with rst > flush > (stall masks push/pop).
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= PW'(ptr_inc(32'(wr_ptr_r), 32'(DEPTH)));
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= PW'(ptr_inc(32'(rd_ptr_r), 32'(DEPTH)));
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Payload storage write; left unreset so it can map onto LUTRAM.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= in_data_i;
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Self-checking bench for pipe_elastic_stage: a DEPTH=2 instance for reset,
// fill/drain, flush, stall, reset-mid-stream and bypass latency; a DEPTH=3
// instance for pointer wrap under a toggling out_ready. A queue scoreboard
// records accepted payloads and checks every output transfer in order.
module tb_pipe_elastic_stage;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   // DEPTH=2 instance
   logic       flush2, stall2, iv2, ir2, ov2, or2;
   logic [7:0] id2, od2;
   logic [1:0] cnt2;
   // DEPTH=3 instance
   logic       flush3, stall3, iv3, ir3, ov3, or3;
   logic [7:0] id3, od3;
   logic [1:0] cnt3;

   pipe_elastic_stage #(.DATA_WIDTH(8), .DEPTH(2)) u_dut2 (
      .clk(clk), .rst(rst), .flush_i(flush2), .stall_i(stall2),
      .in_valid_i(iv2), .in_ready_o(ir2), .in_data_i(id2),
      .out_valid_o(ov2), .out_ready_i(or2), .out_data_o(od2), .count_o(cnt2));

   pipe_elastic_stage #(.DATA_WIDTH(8), .DEPTH(3)) u_dut3 (
      .clk(clk), .rst(rst), .flush_i(flush3), .stall_i(stall3),
      .in_valid_i(iv3), .in_ready_o(ir3), .in_data_i(id3),
      .out_valid_o(ov3), .out_ready_i(or3), .out_data_o(od3), .count_o(cnt3));

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] sb2[$];
   logic [7:0] sb3[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One DEPTH=2 cycle: inputs already driven at negedge; sample, score, advance.
   task automatic cyc2(input string tag);
      logic [7:0] e;
      #1;
      if (iv2 && ir2) sb2.push_back(id2);
      if (ov2 && or2) begin
         if (sb2.size() == 0) begin
            chk({tag, "_unexpected_out"}, 32'(od2), 32'hFFFF_FFFF);
         end else begin
            e = sb2.pop_front();
            chk({tag, "_sb"}, 32'(od2), 32'(e));
         end
      end
      chk({tag, "_cnt_le_depth"}, 32'(cnt2 <= 2'd2), 32'd1);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle2();
      flush2 = 1'b0; stall2 = 1'b0; iv2 = 1'b0; or2 = 1'b0; id2 = 8'h00;
   endtask

   initial begin
      int sent;
      int got;
      logic [7:0] e;
      rst = 1'b1;
      idle2();
      flush3 = 1'b0; stall3 = 1'b0; iv3 = 1'b0; or3 = 1'b0; id3 = 8'h00;

      // Reset held for two cycles.
      @(negedge clk); #1;
      chk("rst_in_ready", 32'(ir2), 32'd0);
      chk("rst_out_valid", 32'(ov2), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(ir2), 32'd1);
      chk("post_rst_out_valid", 32'(ov2), 32'd0);
      chk("post_rst_count", 32'(cnt2), 32'd0);
      chk("post_rst_data", 32'(od2), 32'd0);
      chk("post_rst_count3", 32'(cnt3), 32'd0);

      // Fill with out_ready low.
      iv2 = 1'b1; id2 = 8'h0A; cyc2("fill_a");
      id2 = 8'h0B; cyc2("fill_b");
      #1;
      chk("full_count", 32'(cnt2), 32'd2);
      chk("full_in_ready", 32'(ir2), 32'd0);
      id2 = 8'h0C; cyc2("fill_refused");
      chk("refused_count", 32'(cnt2), 32'd2);
      chk("refused_sb_depth", 32'(sb2.size()), 32'd2);

      // Drain in order.
      iv2 = 1'b0; or2 = 1'b1; #1;
      chk("drain_head_a", 32'(od2), 32'h0A);
      cyc2("drain_a");
      #1;
      chk("drain_count1", 32'(cnt2), 32'd1);
      chk("drain_head_b", 32'(od2), 32'h0B);
      cyc2("drain_b");
      #1;
      chk("drain_count0", 32'(cnt2), 32'd0);
      chk("drain_empty_valid", 32'(ov2), 32'd0);
      chk("drain_empty_data", 32'(od2), 32'd0);

      // Flush a two-entry stage while upstream offers data.
      or2 = 1'b0; iv2 = 1'b1; id2 = 8'h11; cyc2("pre_flush1");
      id2 = 8'h22; cyc2("pre_flush2");
      flush2 = 1'b1; or2 = 1'b1; id2 = 8'h99; #1;
      chk("flush_in_ready", 32'(ir2), 32'd0);
      chk("flush_out_valid", 32'(ov2), 32'd0);
      @(posedge clk); @(negedge clk);
      sb2.delete();
      flush2 = 1'b0; iv2 = 1'b0; or2 = 1'b0; #1;
      chk("flush_count", 32'(cnt2), 32'd0);
      chk("flush_out_valid_after", 32'(ov2), 32'd0);

      // Stall three cycles with both sides requesting.
      iv2 = 1'b1; id2 = 8'h33; cyc2("pre_stall1");
      id2 = 8'h44; cyc2("pre_stall2");
      stall2 = 1'b1; or2 = 1'b1; id2 = 8'h77;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_in_ready", 32'(ir2), 32'd0);
         chk("stall_out_valid", 32'(ov2), 32'd0);
         chk("stall_count", 32'(cnt2), 32'd2);
         chk("stall_data", 32'(od2), 32'h33);
         @(posedge clk); @(negedge clk);
      end
      stall2 = 1'b0; iv2 = 1'b0;
      cyc2("post_stall1");
      cyc2("post_stall2");
      #1;
      chk("post_stall_count", 32'(cnt2), 32'd0);
      chk("post_stall_sb_empty", 32'(sb2.size()), 32'd0);

      // Flush wins over stall.
      or2 = 1'b0; iv2 = 1'b1; id2 = 8'h5A; cyc2("pre_fs");
      iv2 = 1'b0; flush2 = 1'b1; stall2 = 1'b1;
      @(posedge clk); @(negedge clk);
      sb2.delete();
      flush2 = 1'b0; stall2 = 1'b0; #1;
      chk("flush_stall_count", 32'(cnt2), 32'd0);

      // Reset mid-stream drops everything.
      iv2 = 1'b1; id2 = 8'h6B; cyc2("pre_rst");
      iv2 = 1'b0; rst = 1'b1; #1;
      chk("rst_mid_in_ready", 32'(ir2), 32'd0);
      @(posedge clk); @(negedge clk);
      sb2.delete();
      rst = 1'b0; #1;
      chk("rst_mid_count", 32'(cnt2), 32'd0);
      chk("rst_mid_out_valid", 32'(ov2), 32'd0);

      // Latency from an empty stage with downstream ready.
      idle2();
      iv2 = 1'b1; id2 = 8'h55; or2 = 1'b1; #1;
`ifdef PIPE_BYPASS_EN
      chk("byp_same_valid", 32'(ov2), 32'd1);
      chk("byp_same_data", 32'(od2), 32'h55);
      cyc2("byp");
      iv2 = 1'b0; or2 = 1'b0; #1;
      chk("byp_count", 32'(cnt2), 32'd0);
`else
      chk("lat_same_valid", 32'(ov2), 32'd0);
      cyc2("lat_push");
      iv2 = 1'b0; #1;
      chk("lat_next_valid", 32'(ov2), 32'd1);
      chk("lat_next_data", 32'(od2), 32'h55);
      chk("lat_next_count", 32'(cnt2), 32'd1);
      cyc2("lat_pop");
      #1;
      chk("lat_final_count", 32'(cnt2), 32'd0);
`endif
      idle2();

      // DEPTH=3 wrap: stream 0..9 with out_ready toggling.
      sent = 0;
      got  = 0;
      for (int c = 0; c < 200 && got < 10; c++) begin
         iv3 = (sent < 10);
         id3 = sent[7:0];
         or3 = (c % 2 == 0);
         #1;
         if (iv3 && ir3) begin
            sb3.push_back(id3);
            sent++;
         end
         if (ov3 && or3) begin
            if (sb3.size() == 0) begin
               chk("wrap_unexpected_out", 32'(od3), 32'hFFFF_FFFF);
            end else begin
               e = sb3.pop_front();
               chk("wrap_order", 32'(od3), 32'(e));
               chk("wrap_value", 32'(od3), 32'(got));
            end
            got++;
         end
         chk("wrap_cnt_le_depth", 32'(cnt3 <= 2'd3), 32'd1);
         @(posedge clk); @(negedge clk);
      end
      iv3 = 1'b0; or3 = 1'b0;
      chk("wrap_received", 32'(got), 32'd10);
      #1;
      chk("wrap_final_count", 32'(cnt3), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
